// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV32I core: one datapath phase per cycle,
// memory phases stretched on mem_ready. Optional perf counters under MULTICYCLE_PERF_EN.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic        br_cond,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        adr_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC_R = 4'd7,
        S_EXEC_I = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_JAL    = 4'd11,
        S_JALR   = 4'd12,
        S_LINK   = 4'd13,
        S_UPPER  = 4'd14,
        S_TRAP   = 4'd15
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   mem_busy;

    assign mem_busy = ((state_q == S_MEMRD) || (state_q == S_MEMWR)) && !mem_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC_R: state_d = S_ALUWB;
            S_EXEC_I: state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JAL:    state_d = S_LINK;
            S_JALR:   state_d = S_LINK;
            S_LINK:   state_d = S_FETCH;
            S_UPPER:  state_d = S_ALUWB;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
        // Dropping start aborts to IDLE, but an in-flight data access must finish first.
        if (!start && !mem_busy) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        illegal_d = illegal_q;
        if ((state_q == S_IDLE) && (state_d == S_FETCH)) begin
            illegal_d = 1'b0;
        end
        if (state_d == S_TRAP) begin
            illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMRD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = br_cond;
            end
            S_JAL: pc_write = 1'b1;
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            S_LINK: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_write  = 1'b1;
            end
            S_UPPER: begin
                alu_src_a = (opcode == OP_LUI) ? 2'b11 : 2'b01;
                alu_src_b = 2'b01;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;

`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_q, instret_q;
    logic        retire;

    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEMWB) || (state_q == S_MEMWR) || (state_q == S_ALUWB) ||
                     (state_q == S_BRANCH) || (state_q == S_LINK));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != S_IDLE) cycle_q <= cycle_q + 32'd1;
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: route-based reference model checked every
// negative clock edge, plus literal state/output checkpoints.
module tb_multicycle_ctrl;

`ifdef MULTICYCLE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        br_cond = 1'b0;
    logic        mem_ready = 1'b1;
    logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic [3:0]  state;
    logic        illegal;
    logic [31:0] cycle_cnt, instret_cnt;

    int total = 0;
    int bad = 0;
    bit go = 1'b0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .br_cond(br_cond),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src), .state(state), .illegal(illegal),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instruction class is a route of phases after DECODE; the route ends back in FETCH.
    function automatic int route_at(input logic [6:0] opc, input int k);
        int r[$];
        case (opc)
            7'b0000011: r = '{3, 4, 5};
            7'b0100011: r = '{3, 6};
            7'b0110011: r = '{7, 9};
            7'b0010011: r = '{8, 9};
            7'b1100011: r = '{10};
            7'b1101111: r = '{11, 13};
            7'b1100111: r = '{12, 13};
            7'b0110111: r = '{14, 9};
            7'b0010111: r = '{14, 9};
            default:    r = '{15};
        endcase
        return (k < r.size()) ? r[k] : 1;
    endfunction

    // {adr_src, mem_read, mem_write, reg_write, a, b, op, result_src}
    function automatic logic [11:0] ctl_word(input int s, input logic [6:0] opc);
        case (s)
            1:  return 12'b0_1_0_0_00_10_00_10;
            2:  return 12'b0_0_0_0_01_01_00_00;
            3:  return 12'b0_0_0_0_10_01_00_00;
            4:  return 12'b1_1_0_0_00_00_00_00;
            5:  return 12'b0_0_0_1_00_00_00_01;
            6:  return 12'b1_0_1_0_00_00_00_00;
            7:  return 12'b0_0_0_0_10_00_10_00;
            8:  return 12'b0_0_0_0_10_01_10_00;
            9:  return 12'b0_0_0_1_00_00_00_00;
            10: return 12'b0_0_0_0_10_00_01_00;
            12: return 12'b0_0_0_0_10_01_00_10;
            13: return 12'b0_0_0_1_01_10_00_10;
            14: return (opc == 7'b0110111) ? 12'b0_0_0_0_11_01_00_00 : 12'b0_0_0_0_01_01_00_00;
            default: return 12'b0;
        endcase
    endfunction

    int          m_state = 0;
    int          m_pos = 0;
    logic [6:0]  m_op = 7'd0;
    logic        m_ill = 1'b0;
    logic [31:0] m_cyc = 32'd0;
    logic [31:0] m_ret = 32'd0;

    always @(posedge clk or negedge rst) begin : model_step
        int nxt;
        int pos;
        logic [6:0] op;
        if (!rst) begin
            m_state <= 0;
            m_pos   <= 0;
            m_ill   <= 1'b0;
            m_cyc   <= 32'd0;
            m_ret   <= 32'd0;
        end else begin
            pos = m_pos;
            op  = m_op;
            if (m_state == 0)
                nxt = start ? 1 : 0;
            else if ((m_state == 1 || m_state == 4 || m_state == 6) && !mem_ready)
                nxt = (m_state == 1 && !start) ? 0 : m_state;
            else if (!start)
                nxt = 0;
            else if (m_state == 15)
                nxt = 15;
            else if (m_state == 1)
                nxt = 2;
            else if (m_state == 2) begin
                op  = opcode;
                nxt = route_at(opcode, 0);
                pos = 1;
            end else begin
                nxt = route_at(m_op, m_pos);
                pos = m_pos + 1;
            end
            m_state <= nxt;
            m_pos   <= pos;
            m_op    <= op;
            if (m_state != 0) m_cyc <= m_cyc + 32'd1;
            if (nxt == 1 && (m_state == 5 || m_state == 6 || m_state == 9 ||
                             m_state == 10 || m_state == 13))
                m_ret <= m_ret + 32'd1;
            if (nxt == 15) m_ill <= 1'b1;
            else if (m_state == 0 && nxt == 1) m_ill <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (go) begin
            check("state", {28'd0, state}, m_state);
            check("ctl", {20'd0, adr_src, mem_read, mem_write, reg_write, alu_src_a,
                          alu_src_b, alu_op, result_src}, {20'd0, ctl_word(m_state, opcode)});
            check("pc_write", {31'd0, pc_write},
                  {31'd0, (m_state == 1 && mem_ready) || (m_state == 10 && br_cond) ||
                          m_state == 11 || m_state == 12});
            check("ir_write", {31'd0, ir_write}, {31'd0, m_state == 1 && mem_ready});
            check("illegal", {31'd0, illegal}, {31'd0, m_ill});
            check("cycle_cnt", cycle_cnt, PERF ? m_cyc : 32'd0);
            check("instret_cnt", instret_cnt, PERF ? m_ret : 32'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic te(input int s);
        tick();
        check("state_lit", {28'd0, state}, s);
    endtask

    initial begin
        #2 rst = 1'b0;
        go = 1'b1;
        tick();
        tick();
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_enables", {26'd0, pc_write, ir_write, mem_read, mem_write, reg_write, illegal}, 32'd0);
        check("rst_cnt", cycle_cnt | instret_cnt, 32'd0);

        rst = 1'b1; start = 1'b1; mem_ready = 1'b1; opcode = 7'b0110011;
        te(1); te(2); te(7);
        check("r_rw_exec", {31'd0, reg_write}, 32'd0);
        te(9);
        check("r_rw_wb", {31'd0, reg_write}, 32'd1);
        te(1);
        check("r_instret", instret_cnt, PERF ? 32'd1 : 32'd0);
        check("r_cycles", cycle_cnt, PERF ? 32'd4 : 32'd0);

        // load with two wait cycles in MEMRD: 7 cycles total
        opcode = 7'b0000011;
        te(2); te(3);
        mem_ready = 1'b0;
        te(4);
        check("ld_adr", {31'd0, adr_src}, 32'd1);
        te(4); te(4);
        check("ld_adr_wait", {31'd0, adr_src}, 32'd1);
        mem_ready = 1'b1;
        te(5); te(1);
        check("ld_cycles", cycle_cnt, PERF ? 32'd11 : 32'd0);

        opcode = 7'b1100011; br_cond = 1'b0;
        te(2); te(10);
        check("br_nt_pcw", {31'd0, pc_write}, 32'd0);
        te(1);
        br_cond = 1'b1;
        te(2); te(10);
        check("br_t_pcw", {31'd0, pc_write}, 32'd1);
        te(1);
        br_cond = 1'b0;
        check("br_cycles", cycle_cnt, PERF ? 32'd17 : 32'd0);

        opcode = 7'b0100011; te(2); te(3); te(6); te(1);
        opcode = 7'b0010011; te(2); te(8); te(9); te(1);
        opcode = 7'b1101111; te(2); te(11);
        check("jal_pcw", {31'd0, pc_write}, 32'd1);
        te(13); te(1);
        opcode = 7'b1100111; te(2); te(12); te(13); te(1);
        opcode = 7'b0110111; te(2); te(14);
        check("lui_a", {30'd0, alu_src_a}, 32'd3);
        te(9); te(1);
        opcode = 7'b0010111; te(2); te(14);
        check("auipc_a", {30'd0, alu_src_a}, 32'd1);
        te(9); te(1);
        check("instret_10", instret_cnt, PERF ? 32'd10 : 32'd0);

        // abort during a stalled store: access completes, then IDLE
        opcode = 7'b0100011; te(2); te(3);
        mem_ready = 1'b0;
        te(6);
        start = 1'b0;
        te(6);
        check("wr_hold", {31'd0, mem_write}, 32'd1);
        te(6);
        mem_ready = 1'b1;
        #1 check("wr_done", {31'd0, mem_write}, 32'd1);
        te(0);
        check("wr_abort_ret", instret_cnt, PERF ? 32'd10 : 32'd0);
        start = 1'b1;
        te(1);

        // stalled FETCH aborts immediately
        mem_ready = 1'b0;
        te(1);
        check("fetch_stall_irw", {30'd0, ir_write, pc_write}, 32'd0);
        start = 1'b0;
        te(0);
        start = 1'b1; mem_ready = 1'b1;
        te(1);

        opcode = 7'b1111111;
        te(2); te(15);
        check("trap_ill", {31'd0, illegal}, 32'd1);
        te(15);
        start = 1'b0;
        te(0);
        check("idle_ill", {31'd0, illegal}, 32'd1);
        start = 1'b1;
        te(1);
        check("ill_clear", {31'd0, illegal}, 32'd0);

        opcode = 7'b0110011; te(2); te(7);
        start = 1'b0;
        te(0);
        start = 1'b1;
        te(1);

        // asynchronous reset mid-load
        opcode = 7'b0000011; te(2); te(3);
        #2 rst = 1'b0;
        #1 check("arst_state", {28'd0, state}, 32'd0);
        check("arst_en", {27'd0, mem_read, mem_write, reg_write, pc_write, ir_write}, 32'd0);
        check("arst_cnt", cycle_cnt | instret_cnt, 32'd0);
        te(0);
        rst = 1'b1;
        te(1); te(2); te(3); te(4); te(5); te(1);
        check("post_rst_ret", instret_cnt, PERF ? 32'd1 : 32'd0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the RV32I core. It replaces the single-cycle control path with a 16-state Moore/Mealy FSM that drives the shared datapath (PC, IR, register file, ALU, unified memory) one phase per cycle. It sits between the instruction register and the datapath muxes, and stretches memory phases against a `mem_ready` handshake. It reports illegal opcodes and, optionally, cycle and retired-instruction counts.

## Interface
- No parameters.
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  run enable; low forces return to IDLE (see Operation).
- `opcode`  in  7  IR[6:0].
- `br_cond`  in  1  branch-taken from branch logic, valid in BRANCH.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`  out  1  PC load enable.
- `ir_write`  out  1  IR and old-PC load enable.
- `adr_src`  out  1  memory address mux: 0=PC, 1=ALUOut register.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  2  00=PC, 01=oldPC, 10=rs1 reg, 11=zero.
- `alu_src_b`  out  2  00=rs2 reg, 01=imm, 10=const 4.
- `alu_op`  out  2  00=add, 01=branch compare, 10=funct decode.
- `result_src`  out  2  00=ALUOut reg, 01=mem data reg, 10=ALU result direct.
- `state`  out  4  current state encoding.
- `illegal`  out  1  sticky, set when entering TRAP.
- `cycle_cnt`  out  32  active-cycle counter.
- `instret_cnt`  out  32  retired-instruction counter.

## Operation
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC_R 7, EXEC_I 8, ALUWB 9, BRANCH 10, JAL 11, JALR 12, LINK 13, UPPER 14, TRAP 15.
- All outputs default to 0. Each state drives only the outputs listed for it.
- IDLE:
  - No outputs driven.
  - Goes to FETCH when `start`=1.
- FETCH:
  - Drives adr_src=0, mem_read=1, a=00, b=10, op=00, result_src=10.
  - `ir_write` and `pc_write` are both equal to `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; otherwise goes to DECODE.
- DECODE:
  - Drives a=01, b=01, op=00; the branch/JAL target is latched into ALUOut.
  - Next state by opcode: 0000011/0100011 → MEMADR; 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111/0010111 → UPPER; any other → TRAP.
- MEMADR:
  - Drives a=10, b=01, op=00.
  - Load goes to MEMRD; store goes to MEMWR.
- MEMRD:
  - Drives adr_src=1, mem_read=1.
  - Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: drives result_src=01, reg_write=1; then FETCH.
- MEMWR:
  - Drives adr_src=1, mem_write=1.
  - Holds until `mem_ready`, then goes to FETCH.
- EXEC_R: drives a=10, b=00, op=10; then ALUWB.
- EXEC_I: drives a=10, b=01, op=10; then ALUWB.
- ALUWB: drives result_src=00, reg_write=1; then FETCH.
- BRANCH:
  - Drives a=10, b=00, op=01, result_src=00.
  - `pc_write` equals `br_cond`.
  - Then FETCH.
- JAL: drives result_src=00, pc_write=1; then LINK.
- JALR: drives a=10, b=01, op=00, result_src=10, pc_write=1; then LINK.
- LINK: drives a=01, b=10, op=00, result_src=10, reg_write=1 (rd ← oldPC+4); then FETCH.
- UPPER:
  - Drives a=11 for LUI or a=01 for AUIPC, with b=01, op=00.
  - Then ALUWB.
- TRAP:
  - No outputs driven; `illegal` is set to 1.
  - Exits only through `start`=0 (to IDLE) or reset.
- `start`=0 sampled at any edge moves to IDLE next cycle, with two exceptions:
  - In MEMRD/MEMWR while `mem_ready`=0, the controller stays until the access completes, then goes to IDLE.
  - In FETCH while `mem_ready`=0, it goes to IDLE immediately with no pc_write.
- `illegal` clears only on reset or on the IDLE→FETCH transition.

## Timing
- Reset values: state=IDLE, all outputs 0, counters 0, illegal=0.
- Outputs are combinational from state. `pc_write` and `ir_write` are additionally Mealy on `mem_ready` (FETCH) and `br_cond` (BRANCH).
- Latency with zero-wait memory (`mem_ready`=1 every cycle):
  - R-type/I-type/LUI/AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store, JAL, JALR: 4 cycles.
  - Branch: 3 cycles.
- Each memory wait cycle adds 1 cycle to the instruction.
- Reset assertion mid-instruction returns to IDLE asynchronously; no partial write is asserted after reset.

## Configuration
- `MULTICYCLE_PERF_EN` defined:
  - `cycle_cnt` increments every cycle that state≠IDLE.
  - `instret_cnt` increments on every transition into FETCH from a completing state (MEMWB, MEMWR, ALUWB, BRANCH, LINK). It does not increment from IDLE or TRAP.
  - Both counters wrap modulo 2^32.
- Undefined: both counters are tied to constant 0 and no counter flops exist.

## Test plan
- Reset low, then high with start=1 and mem_ready=1 → state goes 0,1,2 on successive edges; all enables are 0 in IDLE.
- Opcode 0110011 with zero-wait memory → states 1,2,7,9,1; reg_write high only in state 9; instret_cnt goes 0→1 after 4 active cycles.
- Load with mem_ready low for 2 cycles in MEMRD → MEMRD held 3 cycles; total 7 cycles; adr_src=1 throughout MEMRD.
- Branch with br_cond=0, then a branch with br_cond=1 → pc_write low, then high, in state 10; each branch takes 3 cycles.
- Opcode 1111111 → TRAP (15), illegal=1 held; start=0 → IDLE; start=1 → FETCH with illegal=0.
- start=0 during MEMWR with mem_ready=0 → mem_write stays high until mem_ready=1, then state=IDLE.
